// File: rtl/smart_bus_column_drain_if.sv
// Valid/ready result stream between a column drain controller and the writeback path.
// The drain side is the master (drives data/valid); the writeback side is the slave.
interface smart_bus_column_drain_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/smart_bus_column_drain.sv
// Column drain controller: walks the column's MAC rows one at a time over the shared
// vertical smart bus and queues each row result into a local FIFO for writeback.
module smart_bus_column_drain #(
    parameter  int WORD_SIZE  = 16,
    parameter  int NUM_ROWS   = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     drain_start_in,
    output logic                     drain_busy_out,
    output logic                     drain_done_out,
    output logic [NUM_ROWS-1:0]      select_bottom_out_smart_out,
    input  logic [WORD_SIZE-1:0]     vertical_smart_bus_in,
    smart_bus_column_drain_if.master out_if,
    output logic [CNT_W-1:0]         fifo_count_out
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t               state_q;
    logic [ROW_W-1:0]     row_idx_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 full;
    logic                 pop;
    logic                 capture;

    // A full FIFO can still accept a row in the same cycle the consumer pops its head,
    // so the drain only stalls when the FIFO is full and nothing is leaving.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first; a path that
        // leaves one unassigned would infer a latch.
        select_bottom_out_smart_out = '0;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        pop     = out_if.out_valid && out_if.out_ready;
        capture = (state_q == DRAIN) && (!full || pop);
        if (capture) begin
            select_bottom_out_smart_out[row_idx_q] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({capture, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order across always blocks.
        if (rst) begin
            state_q   <= IDLE;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (drain_start_in) begin
                        state_q   <= DRAIN;
                        row_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (capture) begin
                        if (row_idx_q == ROW_W'(NUM_ROWS - 1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            row_idx_q <= row_idx_q + ROW_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers and count,
    // so stale entries are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= vertical_smart_bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign out_if.out_valid = (count_q != '0);
    assign fifo_count_out   = count_q;
    assign drain_busy_out   = busy_q;
    assign drain_done_out   = done_q;
endmodule

// File: tb/tb_smart_bus_column_drain.sv
// Scoreboard bench for the column drain: a depth-8 instance covers the main flows and
// a depth-2 instance covers stall under backpressure.
module tb_smart_bus_column_drain;
    localparam int W = 16;
    localparam int R = 4;

    logic         clk;
    logic         rst;
    logic         drain_start_a, drain_start_b;
    logic         busy_a, done_a, busy_b, done_b;
    logic [R-1:0] sel_a, sel_b;
    logic [W-1:0] bus_a, bus_b;
    logic [3:0]   cnt_a;
    logic [1:0]   cnt_b;

    logic [W-1:0] vals_a [R];
    logic [W-1:0] vals_b [R];
    logic [W-1:0] q_a [$];
    logic [W-1:0] q_b [$];
    int exp_row_a, exp_row_b, pops_a, pops_b, dones_a, dones_b;
    int n_checks, n_pass;

    smart_bus_column_drain_if #(.WORD_SIZE(W)) if_a ();
    smart_bus_column_drain_if #(.WORD_SIZE(W)) if_b ();

    smart_bus_column_drain #(.WORD_SIZE(W), .NUM_ROWS(R), .FIFO_DEPTH(8)) u_dut_a (
        .clk                         (clk),
        .rst                         (rst),
        .drain_start_in              (drain_start_a),
        .drain_busy_out              (busy_a),
        .drain_done_out              (done_a),
        .select_bottom_out_smart_out (sel_a),
        .vertical_smart_bus_in       (bus_a),
        .out_if                      (if_a),
        .fifo_count_out              (cnt_a)
    );

    smart_bus_column_drain #(.WORD_SIZE(W), .NUM_ROWS(R), .FIFO_DEPTH(2)) u_dut_b (
        .clk                         (clk),
        .rst                         (rst),
        .drain_start_in              (drain_start_b),
        .drain_busy_out              (busy_b),
        .drain_done_out              (done_b),
        .select_bottom_out_smart_out (sel_b),
        .vertical_smart_bus_in       (bus_b),
        .out_if                      (if_b),
        .fifo_count_out              (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column model: the selected row's MAC drives the shared bus, idle bus floats to a marker.
    always_comb begin
        bus_a = 16'hDEAD;
        bus_b = 16'hDEAD;
        for (int r = 0; r < R; r++) begin
            if (sel_a[r]) bus_a = vals_a[r];
            if (sel_b[r]) bus_b = vals_b[r];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.out_valid && if_a.out_ready) begin
                chk("a_sb_nonempty", 32'(q_a.size() != 0), 1);
                if (q_a.size() != 0) chk("a_data", if_a.out_data, q_a.pop_front());
                pops_a++;
            end
            if (sel_a != '0) begin
                chk("a_sel_order", 32'(sel_a), 32'(1) << exp_row_a);
                exp_row_a++;
            end
            if (done_a) begin
                chk("a_rows_per_drain", exp_row_a, R);
                exp_row_a = 0;
                dones_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (if_b.out_valid && if_b.out_ready) begin
                chk("b_sb_nonempty", 32'(q_b.size() != 0), 1);
                if (q_b.size() != 0) chk("b_data", if_b.out_data, q_b.pop_front());
                pops_b++;
            end
            if (sel_b != '0) begin
                chk("b_sel_order", 32'(sel_b), 32'(1) << exp_row_b);
                exp_row_b++;
            end
            if (done_b) begin
                chk("b_rows_per_drain", exp_row_b, R);
                exp_row_b = 0;
                dones_b++;
            end
        end
    end

    // Loads the row values, queues their expected order and pulses start for one cycle.
    // Returns just after the edge that moves the DUT into DRAIN.
    task automatic kick_a(input logic [W-1:0] base);
        @(posedge clk); #1;
        for (int r = 0; r < R; r++) begin
            vals_a[r] = base + W'((r + 1) * 'h11);
            q_a.push_back(vals_a[r]);
        end
        drain_start_a = 1'b1;
        @(posedge clk); #1;
        drain_start_a = 1'b0;
    endtask

    task automatic kick_b(input logic [W-1:0] base);
        @(posedge clk); #1;
        for (int r = 0; r < R; r++) begin
            vals_b[r] = base + W'((r + 1) * 'h11);
            q_b.push_back(vals_b[r]);
        end
        drain_start_b = 1'b1;
        @(posedge clk); #1;
        drain_start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < limit);
        chk("a_done_seen", done_a, 1);
    endtask

    task automatic wait_done_b(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_b && n < limit);
        chk("b_done_seen", done_b, 1);
    endtask

    task automatic wait_empty_a(input int limit);
        int n = 0;
        while (cnt_a != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("a_drained", cnt_a, 0);
    endtask

    task automatic wait_empty_b(input int limit);
        int n = 0;
        while (cnt_b != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("b_drained", cnt_b, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        drain_start_a = 1'b0;
        drain_start_b = 1'b0;
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b0;
        for (int r = 0; r < R; r++) begin
            vals_a[r] = '0;
            vals_b[r] = '0;
        end
        exp_row_a = 0; exp_row_b = 0; pops_a = 0; pops_b = 0;
        dones_a = 0; dones_b = 0; n_checks = 0; n_pass = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_sel", sel_a, 0);
        chk("rst_valid", if_a.out_valid, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_count_b", cnt_b, 0);

        // Basic drain: selects on cycles 1-4, done on cycle 5.
        if_a.out_ready = 1'b1;
        kick_a(16'h0000);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t1_sel", 32'(sel_a), (c <= 4) ? (32'(1) << (c - 1)) : 32'(0));
            chk("t1_done", done_a, 32'(c == 5));
            chk("t1_busy", busy_a, 1);
        end
        wait_empty_a(20);

        // Backpressure on the depth-2 instance: two captures, then a held stall.
        kick_b(16'h0500);
        repeat (6) @(negedge clk);
        chk("t2_count_full", cnt_b, 2);
        chk("t2_busy", busy_b, 1);
        chk("t2_sel_stall", sel_b, 0);
        chk("t2_valid", if_b.out_valid, 1);
        @(posedge clk); #1 if_b.out_ready = 1'b1;
        wait_done_b(20);
        wait_empty_b(20);
        chk("t2_pops", pops_b, 4);

        // Start pulses during DRAIN and DONE are ignored.
        d0 = dones_a;
        kick_a(16'h1000);
        @(posedge clk); #1 drain_start_a = 1'b1;
        @(posedge clk); #1 drain_start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_in_done", done_a, 1);
        drain_start_a = 1'b1;
        @(posedge clk); #1 drain_start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_idle", busy_a, 0);
        chk("t4_one_done", dones_a - d0, 1);
        wait_empty_a(20);

        // Back-to-back drains fill the FIFO, then a drain into a full FIFO with a pop each cycle.
        if_a.out_ready = 1'b0;
        kick_a(16'h2000);
        wait_done_a(20);
        kick_a(16'h3000);
        wait_done_a(20);
        chk("t6_full", cnt_a, 8);
        kick_a(16'h4000);
        if_a.out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t3_sel", 32'(sel_a), 32'(1) << (c - 1));
            chk("t3_count", cnt_a, 8);
        end
        wait_done_a(5);
        wait_empty_a(30);

        // Reset after two captures discards everything and suppresses done.
        if_a.out_ready = 1'b0;
        d0 = dones_a;
        kick_a(16'h6000);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        q_a.delete();
        exp_row_a = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy_a, 0);
        chk("t5_sel", sel_a, 0);
        chk("t5_valid", if_a.out_valid, 0);
        chk("t5_count", cnt_a, 0);
        chk("t5_done", done_a, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", dones_a - d0, 0);
        if_a.out_ready = 1'b1;
        kick_a(16'h7000);
        wait_done_a(20);
        wait_empty_a(20);

        chk("end_sb_a", q_a.size(), 0);
        chk("end_sb_b", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end
endmodule
